// File: rtl/ram_access_arbiter.sv
// RAM arbiter between the CPU, a host port and a shared synchronous RAM.
// Host steals single cycles in shared mode; CPU read data stays transparent.
module ram_access_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_cpu_enable,
  input  logic [ADDR_WIDTH-1:0]  in_cpu_address,
  input  logic [DATA_WIDTH-1:0]  in_cpu_write,
  input  logic                   in_cpu_write_enable,
  output logic [DATA_WIDTH-1:0]  out_cpu_read,
  output logic                   out_cpu_stall,
  input  logic                   in_host_req,
  input  logic                   in_host_write_enable,
  input  logic [DATA_WIDTH-1:0]  in_host_write,
  input  logic                   in_host_load_address,
  input  logic [ADDR_WIDTH-1:0]  in_host_address,
  output logic                   out_host_ack,
  output logic [DATA_WIDTH-1:0]  out_host_read,
  output logic                   out_host_read_valid,
  output logic [ADDR_WIDTH-1:0]  out_host_pointer,
  output logic [COUNT_WIDTH-1:0] out_steal_count,
  output logic [ADDR_WIDTH-1:0]  out_ram_address,
  output logic [DATA_WIDTH-1:0]  out_ram_write,
  output logic                   out_ram_write_enable,
  input  logic [DATA_WIDTH-1:0]  in_ram_read
);

  typedef enum logic [1:0] {
    S_EXCL,
    S_CPU,
    S_STEAL
  } state_t;

  state_t state;
  state_t state_next;

  logic                   host_owns;
  logic                   host_ack;
  logic                   steal_hit;
  logic                   cpu_owned_q;
  logic [DATA_WIDTH-1:0]  cpu_capture_q;
  logic                   read_pending_q;
  logic [DATA_WIDTH-1:0]  host_read_q;
  logic [ADDR_WIDTH-1:0]  pointer_q;
  logic [COUNT_WIDTH-1:0] steal_count_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_EXCL;
    else       state <= state_next;
  end

  // Next state and RAM ownership; S_STEAL always returns to S_CPU/S_EXCL,
  // so the CPU gets at least one cycle between steals.
  always_comb begin
    state_next    = state;
    host_owns     = 1'b1;
    out_cpu_stall = 1'b1;
    unique case (state)
      S_EXCL: begin
        state_next = in_cpu_enable ? S_CPU : S_EXCL;
      end
      S_CPU: begin
        host_owns     = 1'b0;
        out_cpu_stall = 1'b0;
        if (!in_cpu_enable)   state_next = S_EXCL;
        else if (in_host_req) state_next = S_STEAL;
        else                  state_next = S_CPU;
      end
      S_STEAL: begin
        state_next = in_cpu_enable ? S_CPU : S_EXCL;
      end
      default: begin
        state_next = S_EXCL;
      end
    endcase
  end

  assign host_ack  = host_owns & in_host_req;
  assign steal_hit = host_ack & (state == S_STEAL);

  // RAM port mux: host uses its pointer, CPU uses its own address.
  always_comb begin
    out_ram_address      = in_cpu_address;
    out_ram_write        = in_cpu_write;
    out_ram_write_enable = in_cpu_write_enable;
    if (host_owns) begin
      out_ram_address      = pointer_q;
      out_ram_write        = in_host_write;
      out_ram_write_enable = host_ack & in_host_write_enable;
    end
  end

  // Host pointer: an explicit load beats the post-access increment.
  always_ff @(posedge clock) begin
    if (reset)                     pointer_q <= '0;
    else if (in_host_load_address) pointer_q <= in_host_address;
    else if (host_ack)             pointer_q <= pointer_q + 1'b1;
  end

  // Saturating count of cycles taken from a running CPU.
  always_ff @(posedge clock) begin
    if (reset) begin
      steal_count_q <= '0;
    end else if (steal_hit && steal_count_q != {COUNT_WIDTH{1'b1}}) begin
      steal_count_q <= steal_count_q + 1'b1;
    end
  end

  // Read-data tracking: remember who owned last cycle's RAM access and
  // hold the data so stalls never disturb what each side sees.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_owned_q    <= 1'b0;
      cpu_capture_q  <= '0;
      read_pending_q <= 1'b0;
      host_read_q    <= '0;
    end else begin
      cpu_owned_q    <= ~host_owns;
      read_pending_q <= host_ack & ~in_host_write_enable;
      if (cpu_owned_q)    cpu_capture_q <= in_ram_read;
      if (read_pending_q) host_read_q   <= in_ram_read;
    end
  end

  assign out_cpu_read        = cpu_owned_q ? in_ram_read : cpu_capture_q;
  assign out_host_read       = read_pending_q ? in_ram_read : host_read_q;
  assign out_host_read_valid = read_pending_q;
  assign out_host_ack        = host_ack;
  assign out_host_pointer    = pointer_q;
  assign out_steal_count     = steal_count_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized bench for ram_access_arbiter with a behavioural RAM/host model.
// Includes a narrow-counter instance to cover steal-count saturation.
module tb_ram_access_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_enable;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_write;
  logic        cpu_write_enable;
  logic [7:0]  cpu_read;
  logic        cpu_stall;
  logic        host_req;
  logic        host_write_enable;
  logic [7:0]  host_write;
  logic        host_load_address;
  logic [15:0] host_address;
  logic        host_ack;
  logic [7:0]  host_read;
  logic        host_read_valid;
  logic [15:0] host_pointer;
  logic [15:0] steal_count;
  logic [15:0] ram_address;
  logic [7:0]  ram_write;
  logic        ram_write_enable;
  logic [7:0]  ram_read;

  logic [7:0]  s_cpu_read;
  logic        s_cpu_stall;
  logic        s_host_ack;
  logic [7:0]  s_host_read;
  logic        s_host_read_valid;
  logic [15:0] s_host_pointer;
  logic [3:0]  s_steal_count;
  logic [15:0] s_ram_address;
  logic [7:0]  s_ram_write;
  logic        s_ram_write_enable;

  ram_access_arbiter dut (
    .clock                (clock),
    .reset                (reset),
    .in_cpu_enable        (cpu_enable),
    .in_cpu_address       (cpu_address),
    .in_cpu_write         (cpu_write),
    .in_cpu_write_enable  (cpu_write_enable),
    .out_cpu_read         (cpu_read),
    .out_cpu_stall        (cpu_stall),
    .in_host_req          (host_req),
    .in_host_write_enable (host_write_enable),
    .in_host_write        (host_write),
    .in_host_load_address (host_load_address),
    .in_host_address      (host_address),
    .out_host_ack         (host_ack),
    .out_host_read        (host_read),
    .out_host_read_valid  (host_read_valid),
    .out_host_pointer     (host_pointer),
    .out_steal_count      (steal_count),
    .out_ram_address      (ram_address),
    .out_ram_write        (ram_write),
    .out_ram_write_enable (ram_write_enable),
    .in_ram_read          (ram_read)
  );

  ram_access_arbiter #(.COUNT_WIDTH(4)) dut_sat (
    .clock                (clock),
    .reset                (reset),
    .in_cpu_enable        (cpu_enable),
    .in_cpu_address       (cpu_address),
    .in_cpu_write         (cpu_write),
    .in_cpu_write_enable  (cpu_write_enable),
    .out_cpu_read         (s_cpu_read),
    .out_cpu_stall        (s_cpu_stall),
    .in_host_req          (host_req),
    .in_host_write_enable (host_write_enable),
    .in_host_write        (host_write),
    .in_host_load_address (host_load_address),
    .in_host_address      (host_address),
    .out_host_ack         (s_host_ack),
    .out_host_read        (s_host_read),
    .out_host_read_valid  (s_host_read_valid),
    .out_host_pointer     (s_host_pointer),
    .out_steal_count      (s_steal_count),
    .out_ram_address      (s_ram_address),
    .out_ram_write        (s_ram_write),
    .out_ram_write_enable (s_ram_write_enable),
    .in_ram_read          (ram_read)
  );

  bit [7:0] ram [65536];
  bit [7:0] ref_mem [65536];
  logic [7:0] wq [$];
  logic [15:0] mptr;
  int n_chk;
  int n_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clock) begin
    if (ram_write_enable) ram[ram_address] <= ram_write;
    ram_read <= ram[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_load(input logic [15:0] a);
    host_load_address = 1'b1;
    host_address      = a;
    @(negedge clock);
    tick();
    host_load_address = 1'b0;
    mptr = a;
  endtask

  // Back-to-back exclusive-mode accesses with req held; data from wq.
  task automatic host_burst(input logic wr, input int n, input string tag);
    logic [15:0] a_prev;
    logic rd_prev;
    a_prev  = '0;
    rd_prev = 1'b0;
    for (int i = 0; i <= n; i++) begin
      host_req          = (i < n);
      host_write_enable = wr;
      host_write        = (wr && i < n) ? wq[i] : 8'h00;
      @(negedge clock);
      if (i < n) begin
        chk({tag, "_ack"}, host_ack, 1);
        chk({tag, "_addr"}, ram_address, mptr);
        chk({tag, "_we"}, ram_write_enable, wr);
      end
      chk({tag, "_valid"}, host_read_valid, rd_prev);
      if (rd_prev) chk({tag, "_data"}, host_read, ref_mem[a_prev]);
      if (i < n) begin
        if (wr) ref_mem[mptr] = wq[i];
        a_prev  = mptr;
        rd_prev = !wr;
        mptr    = mptr + 16'd1;
      end else begin
        rd_prev = 1'b0;
      end
      tick();
    end
    host_req = 1'b0;
  endtask

  initial begin
    int nwr, cpu_i, viol, iter;
    logic prev_rd, prev_stall, first, got_ack, done;
    logic [15:0] prev_addr, ca;
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    cpu_enable = 0;
    cpu_address = '0;
    cpu_write = '0;
    cpu_write_enable = 0;
    host_req = 0;
    host_write_enable = 0;
    host_write = '0;
    host_load_address = 0;
    host_address = '0;
    mptr = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_stall", cpu_stall, 1);
    chk("rst_ack", host_ack, 0);
    chk("rst_valid", host_read_valid, 0);
    chk("rst_hread", host_read, 0);
    chk("rst_ptr", host_pointer, 0);
    chk("rst_cnt", steal_count, 0);
    chk("rst_cpurd", cpu_read, 0);
    tick();

    // Preload 0x0000..0x00FF with a pattern.
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(8'(i) ^ 8'h5A);
    host_load(16'h0000);
    host_burst(1'b1, 256, "pre");

    // Exclusive load and readback.
    host_load(16'h0200);
    wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    host_burst(1'b1, 4, "xw");
    @(negedge clock);
    chk("xw_ptr", host_pointer, 16'h0204);
    tick();
    host_load(16'h0200);
    host_burst(1'b0, 4, "xr");
    chk("xr_ref3", ref_mem[16'h0203], 8'hA3);

    // Pointer wrap.
    host_load(16'hFFFF);
    wq = '{8'h11, 8'h22};
    host_burst(1'b1, 2, "wrap");
    @(negedge clock);
    chk("wrap_ptr", host_pointer, 16'h0001);
    tick();
    host_load(16'hFFFF);
    host_burst(1'b0, 2, "wrap_rd");

    // Load asserted in an ack cycle.
    host_load(16'h0001);
    host_req = 1;
    host_write_enable = 1;
    host_write = 8'h77;
    host_load_address = 1;
    host_address = 16'h1234;
    @(negedge clock);
    chk("coll_ack", host_ack, 1);
    chk("coll_addr", ram_address, 16'h0001);
    ref_mem[16'h0001] = 8'h77;
    tick();
    host_req = 0;
    host_load_address = 0;
    @(negedge clock);
    chk("coll_ptr", host_pointer, 16'h1234);
    tick();

    // Shared mode: CPU streams, host steals 20 writes at 0x8000.
    host_load(16'h8000);
    cpu_enable = 1;
    nwr = 0;
    cpu_i = 0;
    viol = 0;
    prev_rd = 0;
    prev_addr = '0;
    prev_stall = 0;
    first = 1;
    done = 0;
    for (iter = 0; iter < 4000 && !done; iter++) begin
      cpu_write_enable = (cpu_i % 4 == 3);
      ca = cpu_write_enable ? 16'(16'h4000 + cpu_i) : 16'(cpu_i & 8'hFF);
      cpu_address = ca;
      cpu_write = 8'(cpu_i) ^ 8'h33;
      if (!host_req && nwr < 20 && !first && $urandom_range(0, 2) == 0) begin
        host_req = 1;
        host_write_enable = 1;
        host_write = 8'($urandom);
      end
      @(negedge clock);
      got_ack = host_ack;
      chk("sh_ack", host_ack, host_req & cpu_stall);
      if (!first && prev_stall && cpu_stall) viol++;
      if (!cpu_stall) begin
        if (prev_rd) chk("sh_cpurd", cpu_read, ref_mem[prev_addr]);
        chk("sh_caddr", ram_address, ca);
        chk("sh_cwe", ram_write_enable, cpu_write_enable);
        if (cpu_write_enable) ref_mem[ca] = cpu_write;
        prev_rd = !cpu_write_enable;
        prev_addr = ca;
        cpu_i++;
      end
      if (got_ack) begin
        chk("sh_haddr", ram_address, mptr);
        ref_mem[mptr] = host_write;
        mptr = mptr + 16'd1;
        nwr++;
      end
      prev_stall = cpu_stall;
      first = 0;
      tick();
      if (got_ack) host_req = 0;
      if (nwr == 20 && cpu_i >= 256) done = 1;
    end
    chk("sh_timeout", done, 1);
    cpu_enable = 0;
    cpu_write_enable = 0;
    host_req = 0;
    @(negedge clock);
    chk("sh_count", steal_count, nwr);
    chk("sat_count", s_steal_count, (nwr > 15) ? 15 : nwr);
    chk("no_dbl_stall", viol, 0);
    chk("sh_ptr", host_pointer, mptr);
    tick();
    tick();
    host_load(16'h8000);
    host_burst(1'b0, 20, "sh_rb");
    host_load(16'h4000);
    host_burst(1'b0, 32, "cw_rb");

    // Reset in the middle of a steal.
    cpu_enable = 1;
    tick();
    host_req = 1;
    host_write_enable = 1;
    host_write = 8'hEE;
    @(negedge clock);
    chk("rs_cpu_stall", cpu_stall, 0);
    chk("rs_cpu_ack", host_ack, 0);
    tick();
    @(negedge clock);
    chk("rs_steal_stall", cpu_stall, 1);
    chk("rs_steal_ack", host_ack, 1);
    reset = 1;
    tick();
    reset = 0;
    host_req = 0;
    @(negedge clock);
    chk("rs_stall", cpu_stall, 1);
    chk("rs_ack", host_ack, 0);
    chk("rs_valid", host_read_valid, 0);
    chk("rs_cnt", steal_count, 0);
    chk("rs_sat_cnt", s_steal_count, 0);
    chk("rs_ptr", host_pointer, 0);
    tick();
    @(negedge clock);
    chk("rs_resume", cpu_stall, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
